// File: rtl/sram_bank.sv
// sram_bank: parametrised single-port byte-addressed SRAM bus slave.
// Supports valid/ready/size requests, configurable read latency, optional
// zero-fill after reset, size-masked zero-extended read data and an error
// response for misaligned, reserved-size or out-of-range accesses.
module sram_bank #(
  parameter int unsigned AW        = 8,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned CLEAR     = 1,
  parameter int unsigned RANGE_CHK = 1
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic        valid,
  input  logic        write,
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        err,
  output logic [31:0] rdata,
  output logic        init_done
);

  localparam int unsigned Words = 2 ** AW;

  localparam logic [1:0] INIT = 2'd0;
  localparam logic [1:0] IDLE = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  // Number of WAIT edges after the acceptance edge before the response.
  localparam logic [1:0] LAT_INIT = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

  localparam logic [1:0] RST_STATE = (CLEAR != 0) ? INIT : IDLE;
  localparam logic       RST_DONE  = (CLEAR != 0) ? 1'b0 : 1'b1;

  logic [1:0]    state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [AW-1:0] clr_q, clr_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   hold_q, hold_d;

  logic [31:0]   mem [Words];

  logic [AW-1:0] widx;
  logic [4:0]    shamt;
  logic          err_c;
  logic [3:0]    be_base;
  logic [3:0]    be_c;
  logic [31:0]   wdata_sh;
  logic [31:0]   rd_word;
  logic [31:0]   rd_sh;
  logic [31:0]   rd_masked;

  logic          mem_we;
  logic [AW-1:0] mem_idx;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdata;

  assign widx  = addr[AW+1:2];
  assign shamt = {addr[1:0], 3'b000};

  // Access legality: reserved size, misalignment, and optional upper-bit range check.
  always_comb begin
    err_c = (size == 2'd3)
          | ((size == 2'd1) & addr[0])
          | ((size == 2'd2) & (addr[1:0] != 2'd0))
          | ((RANGE_CHK != 0) & ((addr >> (AW + 2)) != 32'd0));
  end

  // Byte enables and lane-aligned write data for the request.
  always_comb begin
    case (size)
      2'd0:    be_base = 4'b0001;
      2'd1:    be_base = 4'b0011;
      default: be_base = 4'b1111;
    endcase
    be_c     = be_base << addr[1:0];
    wdata_sh = wdata << shamt;
  end

  // Read path: select word, right-align, zero-extend to the access size.
  always_comb begin
    rd_word = mem[widx];
    rd_sh   = rd_word >> shamt;
    case (size)
      2'd0:    rd_masked = {24'h0, rd_sh[7:0]};
      2'd1:    rd_masked = {16'h0, rd_sh[15:0]};
      default: rd_masked = rd_sh;
    endcase
  end

  // Next-state logic for the controller, response registers and array port.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    clr_d     = clr_q;
    done_d    = done_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    hold_d    = hold_q;
    mem_we    = 1'b0;
    mem_idx   = widx;
    mem_be    = be_c;
    mem_wdata = wdata_sh;

    case (state_q)
      INIT: begin
        // Zero-fill one word per cycle; requests wait until IDLE.
        mem_we    = 1'b1;
        mem_idx   = clr_q;
        mem_be    = 4'hf;
        mem_wdata = 32'h0;
        clr_d     = clr_q + 1'b1;
        if (clr_q == {AW{1'b1}}) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      IDLE: begin
        if (valid) begin
          if (err_c) begin
            err_d   = 1'b1;
            rdata_d = 32'h0;
            state_d = RESP;
          end else if (write) begin
            err_d   = 1'b0;
            mem_we  = 1'b1;
            state_d = RESP;
          end else begin
            err_d = 1'b0;
            if (RD_LAT <= 1) begin
              rdata_d = rd_masked;
              state_d = RESP;
            end else begin
              // Array sampled now; result is held while WAIT counts down.
              hold_d  = rd_masked;
              cnt_d   = LAT_INIT;
              state_d = WAIT;
            end
          end
        end
      end
      WAIT: begin
        if (cnt_q == 2'd0) begin
          rdata_d = hold_q;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        // RESP: valid seen here belongs to the completing request.
        err_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Controller and response registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= RST_STATE;
      cnt_q   <= 2'd0;
      clr_q   <= '0;
      done_q  <= RST_DONE;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
      hold_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clr_q   <= clr_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      hold_q  <= hold_d;
    end
  end

  // Byte-enabled array write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) begin
          mem[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
    end
  end

  assign ready     = (state_q == RESP);
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign init_done = done_q;

endmodule

// File: tb/tb_sram_bank.sv
// tb_sram_bank: scoreboard bench for sram_bank (AW=8, RD_LAT=3, CLEAR=1).
// The driver pushes expected responses; a negedge monitor pops and compares.
module tb_sram_bank;

  logic        clk;
  logic        rstb;
  logic        valid;
  logic        write;
  logic [31:0] addr;
  logic [1:0]  size;
  logic [31:0] wdata;
  logic        ready;
  logic        err;
  logic [31:0] rdata;
  logic        init_done;

  int checks;
  int errors;
  int cyc;
  logic [31:0] last_rd;

  typedef struct {
    logic        err;
    logic [31:0] rd;
    int          lat;
    int          t0;
    string       nm;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  sram_bank #(
    .AW       (8),
    .RD_LAT   (3),
    .CLEAR    (1),
    .RANGE_CHK(1)
  ) dut (
    .clk      (clk),
    .rstb     (rstb),
    .valid    (valid),
    .write    (write),
    .addr     (addr),
    .size     (size),
    .wdata    (wdata),
    .ready    (ready),
    .err      (err),
    .rdata    (rdata),
    .init_done(init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ready: got ready with err=%0b rdata=%h, want no response",
                 err, rdata);
      end else begin
        mon_e = sb.pop_front();
        if (err !== mon_e.err || rdata !== mon_e.rd || (cyc - mon_e.t0) != mon_e.lat) begin
          errors++;
          $display("FAIL %s: got err=%0b rdata=%h lat=%0d, want err=%0b rdata=%h lat=%0d",
                   mon_e.nm, err, rdata, cyc - mon_e.t0, mon_e.err, mon_e.rd, mon_e.lat);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, want %h", nm, got, want);
    end
  endtask

  // Issue one request at a negedge; returns at the ready negedge (hold) or one later.
  task automatic acc(input logic w, input logic [31:0] a, input logic [1:0] sz,
                     input logic [31:0] wd, input logic e_err, input logic [31:0] e_rd,
                     input int e_lat, input logic hold, input string nm);
    exp_t e;
    int   n;
    valid = 1'b1;
    write = w;
    addr  = a;
    size  = sz;
    wdata = wd;
    if (e_err) last_rd = 32'h0;
    else if (!w) last_rd = e_rd;
    e.err = e_err;
    e.rd  = last_rd;
    e.lat = e_lat;
    e.t0  = cyc;
    e.nm  = nm;
    sb.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready && n < 40);
    if (!ready) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no ready in %0d cycles, want ready", nm, n);
      sb.delete();
    end
    if (!hold) begin
      valid = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    int c0;
    int n;
    logic seen;
    checks  = 0;
    errors  = 0;
    cyc     = 0;
    last_rd = 32'h0;
    rstb    = 1'b0;
    // Read of 0x3FC held through reset and the whole zero-fill.
    valid   = 1'b1;
    write   = 1'b0;
    addr    = 32'h3FC;
    size    = 2'd2;
    wdata   = 32'h0;

    repeat (3) @(negedge clk);
    chk("rst_ready", {31'h0, ready}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_init_done", {31'h0, init_done}, 32'h0);

    // Accepted on the first IDLE edge: 256 fill edges, then 3 read cycles.
    begin
      exp_t e;
      e.err = 1'b0; e.rd = 32'h0; e.lat = 259; e.t0 = cyc; e.nm = "init_read_3fc";
      sb.push_back(e);
    end
    c0   = cyc;
    rstb = 1'b1;
    seen = 1'b0;
    n    = 0;
    do begin
      @(negedge clk);
      n++;
      if (init_done && !seen) begin
        seen = 1'b1;
        chk("init_done_cycle", cyc - c0, 32'd256);
      end
    end while (!ready && n < 400);
    if (!seen) chk("init_done_seen", {31'h0, init_done}, 32'h1);
    if (!ready) begin
      checks++;
      errors++;
      $display("FAIL init_read_timeout: got no ready in %0d cycles, want ready", n);
      sb.delete();
    end
    valid = 1'b0;
    @(negedge clk);

    // Word write then byte/half reads.
    acc(1, 32'h10, 2'd2, 32'h11223344, 0, 32'h0, 1, 0, "wr_w_10");
    acc(0, 32'h10, 2'd0, 32'h0, 0, 32'h00000044, 3, 0, "rd_b_10");
    acc(0, 32'h11, 2'd0, 32'h0, 0, 32'h00000033, 3, 0, "rd_b_11");
    acc(0, 32'h12, 2'd0, 32'h0, 0, 32'h00000022, 3, 0, "rd_b_12");
    acc(0, 32'h13, 2'd0, 32'h0, 0, 32'h00000011, 3, 0, "rd_b_13");
    acc(0, 32'h12, 2'd1, 32'h0, 0, 32'h00001122, 3, 0, "rd_h_12");

    // Half write into upper lane of an all-ones word.
    acc(1, 32'h20, 2'd2, 32'hFFFFFFFF, 0, 32'h0, 1, 0, "wr_w_20");
    acc(1, 32'h22, 2'd1, 32'h0000BEEF, 0, 32'h0, 1, 0, "wr_h_22");
    acc(0, 32'h20, 2'd2, 32'h0, 0, 32'hBEEFFFFF, 3, 0, "rd_w_20");

    // Error responses: 1-cycle latency, rdata forced to 0, no array write.
    acc(0, 32'h01, 2'd1, 32'h0, 1, 32'h0, 1, 0, "err_h_01");
    acc(0, 32'h10, 2'd2, 32'h0, 0, 32'h11223344, 3, 0, "rd_w_10");
    acc(1, 32'h06, 2'd2, 32'hDEADBEEF, 1, 32'h0, 1, 0, "err_w_06");
    acc(1, 32'h10, 2'd3, 32'hAAAAAAAA, 1, 32'h0, 1, 0, "err_sz3_10");
    acc(1, 32'h400, 2'd2, 32'h55555555, 1, 32'h0, 1, 0, "err_range_400");
    acc(0, 32'h04, 2'd2, 32'h0, 0, 32'h0, 3, 0, "rb_w_04");
    acc(0, 32'h10, 2'd2, 32'h0, 0, 32'h11223344, 3, 0, "rb_w_10");
    acc(0, 32'h00, 2'd2, 32'h0, 0, 32'h0, 3, 0, "rb_w_00");
    acc(1, 32'h04, 2'd2, 32'h0BADF00D, 0, 32'h0, 1, 0, "wr_w_04_keeps_rdata");

    // Back-to-back reads with valid held: one access per 4 cycles.
    acc(0, 32'h10, 2'd2, 32'h0, 0, 32'h11223344, 3, 1, "b2b_0");
    acc(0, 32'h20, 2'd2, 32'h0, 0, 32'hBEEFFFFF, 4, 1, "b2b_1");
    acc(0, 32'h13, 2'd0, 32'h0, 0, 32'h00000011, 4, 1, "b2b_2");
    acc(0, 32'h22, 2'd1, 32'h0, 0, 32'h0000BEEF, 4, 0, "b2b_3");

    // Reset during WAIT: response dropped, outputs cleared, zero-fill restarts.
    valid = 1'b1;
    write = 1'b0;
    addr  = 32'h04;
    size  = 2'd2;
    @(negedge clk);
    rstb  = 1'b0;
    valid = 1'b0;
    #1;
    chk("midrst_ready", {31'h0, ready}, 32'h0);
    chk("midrst_err", {31'h0, err}, 32'h0);
    chk("midrst_rdata", rdata, 32'h0);
    chk("midrst_init_done", {31'h0, init_done}, 32'h0);
    repeat (3) @(negedge clk);
    last_rd = 32'h0;
    c0   = cyc;
    rstb = 1'b1;
    n    = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!init_done && n < 400);
    chk("refill_done_cycle", cyc - c0, 32'd256);
    acc(0, 32'h10, 2'd2, 32'h0, 0, 32'h0, 3, 0, "refill_rd_10");
    acc(0, 32'h20, 2'd2, 32'h0, 0, 32'h0, 3, 0, "refill_rd_20");

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_bank.md
# sram_bank

Parametrised single-port, byte-addressed SRAM bus slave. It is the successor to the fixed 1 KiB word SRAM and uses the same valid/ready/size bus semantics. New over the previous generation:
- configurable depth and read latency;
- optional hardware zero-fill after reset;
- size-masked, zero-extended read data;
- an error response for misaligned, reserved-size or out-of-range accesses.

It sits on the core data/instruction bus as the generic on-chip RAM.

## Interface
Parameters:
- AW, 8: word-address bits; capacity is 4·2^AW bytes (8 gives 1 KiB).
- RD_LAT, 1: read latency in cycles, legal range 1..4. Writes always take 1 cycle.
- CLEAR, 1: 1 enables zero-fill of every word after reset.
- RANGE_CHK, 1: 1 flags an error when addr[31:AW+2] != 0. With 0, those bits are ignored (address aliasing).

Ports:
- clk, input, 1: clock, rising edge.
- rstb, input, 1: reset, asynchronous, active-low.
- valid, input, 1: request valid; held by the master until ready.
- write, input, 1: 1 = write, 0 = read.
- addr, input, 32: byte address.
- size, input, 2: 0 = byte, 1 = half, 2 = word, 3 = reserved.
- wdata, input, 32: write data, right-aligned (byte in [7:0], half in [15:0]).
- ready, output, 1: one-cycle completion pulse.
- err, output, 1: error flag; valid only while ready = 1.
- rdata, output, 32: read data, right-aligned and zero-extended to size; registered.
- init_done, output, 1: high once the zero-fill is complete, or immediately after reset when CLEAR = 0.

## Operation
FSM states: INIT, IDLE, WAIT, RESP.

Reset (async, rstb = 0):
- State goes to INIT if CLEAR = 1, otherwise IDLE.
- ready = 0, err = 0, rdata = 0. init_done = 0 if CLEAR = 1, else 1.
- Memory contents are not reset directly.

INIT:
- A counter walks word index 0 .. 2^AW−1, writing 32'h0 with all byte enables, one word per cycle.
- After the last word, the state moves to IDLE and init_done rises on the same edge.
- valid is ignored during INIT: no acceptance and no ready. The request stays pending and is accepted on the first IDLE edge.

IDLE: a request is accepted on the rising edge where valid = 1. Address, size and write are captured. The access is checked at that edge:
- err_c = (size == 3) | (size == 1 & addr[0]) | (size == 2 & addr[1:0] != 0) | (RANGE_CHK & addr[31:AW+2] != 0).

Write (err_c = 0):
- Byte enables are (4'b0001 / 4'b0011 / 4'b1111 for size 0 / 1 / 2) << addr[1:0].
- Data is written as wdata << 8·addr[1:0] at word (addr >> 2) mod 2^AW, on the acceptance edge.
- Goes to RESP.

Read (err_c = 0):
- The array is read at the acceptance edge.
- The result passes through RD_LAT−1 further register stages; a down-counter in WAIT tracks them.
- Data is (word >> 8·addr[1:0]) masked to 8, 16 or 32 bits.
- rdata updates together with ready.

Error (err_c = 1):
- No array write. Goes to RESP with err = 1. rdata is set to 0.
- Latency is 1 cycle regardless of RD_LAT.

RESP:
- ready = 1 for exactly one cycle, then IDLE.
- The valid seen during the RESP cycle belongs to the completing request and is never accepted.

rdata holds its value until the next read or error response. Writes do not change rdata.

Mid-operation reset: the pending response is dropped and the reset values apply. A partially performed zero-fill restarts from word 0.

## Timing
- Request accepted at edge E0:
  - Write or error: ready high in the cycle after E0.
  - Read: ready high in the cycle after edge E0 + (RD_LAT − 1).
- RD_LAT = 1 behaves like the previous generation: ready one cycle after acceptance.
- Throughput is one access per (latency + 1) cycles. The master may present the next request in the cycle after ready, and it is accepted at the following edge.
- Zero-fill lasts 2^AW cycles after rstb deasserts. init_done is high in cycle 2^AW (cycles counted from 0).
- Simultaneous valid and the last INIT edge: the request is not accepted on that edge; acceptance happens on the next edge.

## Test plan
- CLEAR = 1, AW = 8: release reset with valid held high for a read of addr 0x3FC. Required: init_done rises after 256 cycles, then ready with rdata = 0, err = 0.
- Word write of 0x11223344 at 0x10, then byte reads at 0x10..0x13. Required: rdata = 0x44, 0x33, 0x22, 0x11. Half read at 0x12 → 0x00001122.
- Half write of 0xBEEF at 0x22 over a word 0xFFFFFFFF, then word read at 0x20. Required: 0xBEEFFFFF.
- Error cases: half access at 0x1, word access at 0x6, size = 3, and addr = 0x400 with AW = 8. Required: ready 1 cycle after acceptance with err = 1, rdata = 0, and no memory change (verified by a read-back).
- RD_LAT = 3, back-to-back reads with valid held continuously. Required: ready in the cycle after edge E0 + 2 (third cycle after acceptance), one access per 4 cycles, correct data for each.
- Assert rstb low in the WAIT state of a read. Required: ready, err and rdata go to 0 immediately; with CLEAR = 1 the zero-fill restarts and the pending response is never issued.
